// File: rtl/mostra_sequencia_pkg.sv
// Shared MindFocus definitions: display FSM state codes and default LED timing.
package mindfocus_pkg;

  localparam int unsigned ESTADO_W        = 4;
  localparam int unsigned LED_ON_DEFAULT  = 1000;
  localparam int unsigned LED_OFF_DEFAULT = 100;

  typedef enum logic [ESTADO_W-1:0] {
    OCIOSO  = 4'd0,
    CARREGA = 4'd1,
    ACESO   = 4'd2,
    APAGADO = 4'd3,
    FIM     = 4'd4
  } estado_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mostra_sequencia_if.sv
// Game-FSM / memory / LED bundle for mostra_sequencia.
// MOSTRA_SEQ_ABORT_EN adds the abortar request line.
interface mostra_sequencia_if
  import mindfocus_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
);
  logic                iniciar;
  logic [ADDR_W-1:0]   limite;
  logic [3:0]          dado;
  logic [ADDR_W-1:0]   endereco;
  logic [3:0]          leds;
  logic                ocupado;
  logic                fim;
  logic [ESTADO_W-1:0] db_estado;
`ifdef MOSTRA_SEQ_ABORT_EN
  logic                abortar;

  modport master (
    output iniciar, limite, dado, abortar,
    input  endereco, leds, ocupado, fim, db_estado
  );
  modport slave (
    input  iniciar, limite, dado, abortar,
    output endereco, leds, ocupado, fim, db_estado
  );
`else
  modport master (
    output iniciar, limite, dado,
    input  endereco, leds, ocupado, fim, db_estado
  );
  modport slave (
    input  iniciar, limite, dado,
    output endereco, leds, ocupado, fim, db_estado
  );
`endif
endinterface

// File: rtl/mostra_sequencia_temporizador.sv
// Loadable down-counter; expirou flags the last cycle of a loaded interval.
module temporizador #(
  parameter int unsigned W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         carrega,
  input  logic [W-1:0] valor,
  output logic         expirou
);

  logic [W-1:0] cont_q, cont_d;

  always_comb begin
    cont_d = cont_q;
    if (carrega)
      cont_d = valor;
    else if (cont_q != '0)
      cont_d = cont_q - 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cont_q <= '0;
    else        cont_q <= cont_d;
  end

  // Firing at 1 rather than 0 lets the state change land exactly on cycle N.
  assign expirou = (cont_q == W'(1));

endmodule

// File: rtl/mostra_sequencia.sv
// Sequence-display controller: shows entries 0..limite with fixed on/gap timing.
// MOSTRA_SEQ_ABORT_EN enables the abortar input (abort to idle, no fim).
module mostra_sequencia
  import mindfocus_pkg::*;
#(
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned LED_ON_CYCLES  = LED_ON_DEFAULT,
  parameter int unsigned LED_OFF_CYCLES = LED_OFF_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  mostra_sequencia_if.slave bus
);

  localparam int unsigned TW = $clog2(max_u(LED_ON_CYCLES, LED_OFF_CYCLES) + 1);
  localparam logic [TW-1:0] T_ON  = TW'(LED_ON_CYCLES);
  localparam logic [TW-1:0] T_OFF = TW'(LED_OFF_CYCLES);

  estado_t           estado_q, estado_d;
  logic [ADDR_W-1:0] endereco_q, endereco_d;
  logic [ADDR_W-1:0] lim_q, lim_d;
  logic [3:0]        leds_q, leds_d;
  logic              carrega;
  logic [TW-1:0]     valor;
  logic              expirou;

  temporizador #(.W(TW)) u_temporizador (
    .clock   (clock),
    .reset   (reset),
    .carrega (carrega),
    .valor   (valor),
    .expirou (expirou)
  );

  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco_q;
    lim_d      = lim_q;
    leds_d     = leds_q;
    carrega    = 1'b0;
    valor      = '0;
    case (estado_q)
      OCIOSO: begin
        endereco_d = '0;
        leds_d     = '0;
        if (bus.iniciar) begin
          lim_d    = bus.limite;
          estado_d = CARREGA;
        end
      end
      CARREGA: begin
        leds_d   = bus.dado;
        carrega  = 1'b1;
        valor    = T_ON;
        estado_d = ACESO;
      end
      ACESO: begin
        if (expirou) begin
          leds_d   = '0;
          carrega  = 1'b1;
          valor    = T_OFF;
          estado_d = APAGADO;
        end
      end
      APAGADO: begin
        leds_d = '0;
        // Compare before incrementing so a full-range limit never wraps.
        if (expirou) begin
          if (endereco_q == lim_q) begin
            estado_d = FIM;
          end else begin
            endereco_d = endereco_q + 1'b1;
            estado_d   = CARREGA;
          end
        end
      end
      FIM: begin
        endereco_d = '0;
        leds_d     = '0;
        estado_d   = OCIOSO;
      end
      default: begin
        endereco_d = '0;
        leds_d     = '0;
        estado_d   = OCIOSO;
      end
    endcase
`ifdef MOSTRA_SEQ_ABORT_EN
    if (bus.abortar && (estado_q != OCIOSO)) begin
      endereco_d = '0;
      leds_d     = '0;
      carrega    = 1'b0;
      estado_d   = OCIOSO;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= OCIOSO;
      endereco_q <= '0;
      lim_q      <= '0;
      leds_q     <= '0;
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      lim_q      <= lim_d;
      leds_q     <= leds_d;
    end
  end

  assign bus.endereco  = endereco_q;
  assign bus.leds      = leds_q;
  assign bus.ocupado   = (estado_q != OCIOSO);
  assign bus.fim       = (estado_q == FIM);
  assign bus.db_estado = estado_q;

endmodule

// File: doc/mostra_sequencia.md
# mostra_sequencia

Sequence-display controller for the MindFocus game. On a start pulse it walks the sequence memory from address 0 to the round limit. For each entry it lights that entry's LED pattern for a fixed on-time, blanks the LEDs for a fixed gap, then advances. It sits between the main game FSM (which issues `iniciar` and waits for `fim`) and the sequence ROM/RAM plus LED outputs, replacing ad-hoc display timing in the top-level FSM.

## Interface
- `ADDR_W`, 4: width of the sequence address and of the round limit.
- `LED_ON_CYCLES`, 1000: clock cycles each LED pattern is shown; must be ≥1.
- `LED_OFF_CYCLES`, 100: clock cycles of blank gap after each pattern; must be ≥1.

- `clock`  in  1  system clock; single clock domain, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `iniciar`  in  1  start request; sampled only in OCIOSO.
- `limite`  in  ADDR_W  index of the last entry to show (round length − 1).
- `dado`  in  4  memory read data for `endereco`; combinational from memory.
- `endereco`  out  ADDR_W  memory address currently being shown.
- `leds`  out  4  LED drive.
- `ocupado`  out  1  high in every state except OCIOSO.
- `fim`  out  1  one-cycle pulse; the sequence has been fully shown.
- `db_estado`  out  4  current state code, for the 7-segment debug display.

## Operation
- States: OCIOSO=0, CARREGA=1, ACESO=2, APAGADO=3, FIM=4. Other codes fall back to OCIOSO.
- OCIOSO
  - `endereco`=0, `leds`=0.
  - `iniciar`=1 at an edge: latch `limite` into `lim_r`, go to CARREGA.
- CARREGA (1 cycle)
  - Register `dado` into the LED register.
  - Load the timer with `LED_ON_CYCLES`; go to ACESO.
- ACESO: `leds` = latched pattern. When the timer expires, clear the LEDs, load `LED_OFF_CYCLES`, and go to APAGADO.
- APAGADO: `leds`=0. When the timer expires:
  - if `endereco`==`lim_r`, go to FIM;
  - else `endereco`+1, go to CARREGA.
- FIM (1 cycle): `fim`=1, `endereco` returns to 0, go to OCIOSO.
- `iniciar` is ignored while `ocupado`=1.
- `limite` changes after the start edge have no effect.
- `lim_r`=0 shows exactly one entry.
- `dado`=0 is still timed normally; the LEDs simply stay dark.
- Address arithmetic is unsigned, ADDR_W bits. `lim_r`=2^ADDR_W−1 shows every entry, with no wrap before FIM.

## Timing
- Reset values: state OCIOSO, `endereco`=0, `leds`=0, `ocupado`=0, `fim`=0, `db_estado`=0, timer=0, `lim_r`=0.
- Reset asserted mid-operation aborts immediately to the reset values. No `fim` is produced.
- Start: `iniciar` high at edge k gives CARREGA and `ocupado`=1 after edge k. `leds` shows entry 0 after edge k+1.
- Each entry occupies 1 + LED_ON_CYCLES + LED_OFF_CYCLES cycles (CARREGA + ACESO + APAGADO).
- `fim` is high for the single cycle after the last gap. Total from the start edge to the `fim` cycle is (lim_r+1)·(1+ON+OFF) cycles. OCIOSO follows on the next edge.
- `iniciar` asserted during the FIM cycle is ignored. A new start needs an edge in OCIOSO.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.

## Configuration
- Macro `MOSTRA_SEQ_ABORT_EN`.
- Defined: extra input `abortar` (1 bit).
  - While `ocupado`, `abortar`=1 at an edge forces OCIOSO, `leds`=0, `endereco`=0.
  - No `fim` pulse.
  - Abort takes priority over every other transition, including FIM.
- Undefined: the port does not exist, and a sequence always runs to `fim` unless reset.

## Structure
- Shared package `mindfocus_pkg` holds:
  - state localparams (OCIOSO…FIM) and the 4-bit state width;
  - default timing constants LED_ON_DEFAULT=1000 and LED_OFF_DEFAULT=100.
- One sub-module, `temporizador`: loadable down-counter.
  - Inputs: `carrega`, `valor`.
  - Output: `expirou`, high when the count reaches 1 so the state change lands exactly on cycle N.
  - Width is $clog2(max(ON,OFF)+1).
- The top level holds the FSM, the address counter, `lim_r` and the LED register.

## Test plan
Run with ON=4, OFF=2, memory pattern = {0001,0010,0100,1000,…}.
- Reset release, idle 10 cycles → `ocupado`=0, `leds`=0000, `endereco`=0, `fim` never high.
- `limite`=0, `iniciar` 1 cycle:
  - `leds`=0001 for 4 cycles starting one cycle after the start edge;
  - then 0000 for 2 cycles;
  - `fim` pulses on cycle 7 after the start edge.
- `limite`=3:
  - LED patterns 0001,0010,0100,1000 in order, each 4 on / 2 off;
  - `endereco` steps 0→3;
  - `fim` pulses on cycle 28 after the start edge.
- `iniciar` held high for the whole `limite`=2 run and `limite` changed to 5 mid-run:
  - exactly 3 entries are shown and one `fim`;
  - after FIM the block restarts only once `iniciar` is still high in OCIOSO.
- Reset asserted during ACESO of entry 2 → `leds`=0000, `endereco`=0 and `ocupado`=0 immediately (asynchronous), no `fim`.
- With `MOSTRA_SEQ_ABORT_EN`: `abortar` pulsed in APAGADO of entry 1 → OCIOSO next cycle, `leds`=0000, no `fim`; a subsequent `iniciar` restarts from entry 0.
